unidade_controle_jogo: RTL and testbench
========================================

Name: unidade_controle_jogo

Overview:
- Moore FSM that sequences the ultimate tic-tac-toe datapath (`fluxo_dados`).
- Drives the register clears/enables, the macro-input mux select and the edge-detector reset.
- Tracks the current player and enforces a per-move timeout.
- Sits beside `fluxo_dados` in the top level. It consumes `tem_jogada`, `escolhe_macro` and `fim_jogo` from that block and produces every control strobe it needs.

Parameters:
- TIMEOUT_CICLOS, 5000, clock cycles a player may wait in a move-waiting state before the game is aborted. Must be ≥ 2.
- CONT_W, $clog2(TIMEOUT_CICLOS), width of the timeout counter (derived; not overridden).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start/restart request, level, sampled on clock
- tem_jogada  in  1  one-cycle pulse from the datapath edge detector
- escolhe_macro  in  1  1 = target macro cell already decided; the next player picks a free macro
- fim_jogo  in  1  1 = game over, from datapath
- zeraEdge  out  1  edge-detector reset
- zeraR_micro  out  1  micro register clear
- zeraR_macro  out  1  macro register clear
- registraR_micro  out  1  micro register enable
- registraR_macro  out  1  macro register enable
- sinal_macro  out  1  macro mux select: 1 = buttons, 0 = micro register
- jogador  out  1  current player: 0 = X, 1 = O
- pronto  out  1  high in FIM
- timeout  out  1  high in FIM_TIMEOUT
- db_estado  out  4  state encoding, debug

Behaviour:
- Reset (reset=0, async):
  - State INICIAL (0x0), jogador=0, livre=0, counter=0.
  - All outputs 0; db_estado=0x0.
- Outputs are Moore, decoded from the state register. Unlisted outputs are 0 in each state.
- INICIAL (0x0): iniciar=1 -> PREPARA.
- PREPARA (0x1):
  - zeraEdge=zeraR_micro=zeraR_macro=1.
  - jogador cleared to 0.
  - Next: ESPERA_MACRO.
- ESPERA_MACRO (0x2):
  - sinal_macro=1; counter runs.
  - tem_jogada=1 -> REGISTRA_MACRO.
  - Counter reaching TIMEOUT_CICLOS-1 -> FIM_TIMEOUT.
- REGISTRA_MACRO (0x3): sinal_macro=1, registraR_macro=1. Next: ESPERA_MICRO.
- ESPERA_MICRO (0x4):
  - Counter runs.
  - tem_jogada -> REGISTRA_MICRO; counter expiry -> FIM_TIMEOUT.
- REGISTRA_MICRO (0x5): registraR_micro=1. Next: ESPERA_RAM.
- ESPERA_RAM (0x6): no strobes. Covers the one-cycle synchronous RAM read of the new micro address. Next: VERIFICA.
- VERIFICA (0x7): samples the datapath flags.
  - fim_jogo=1 -> FIM (fim_jogo has priority).
  - Otherwise latch livre<=escolhe_macro.
  - Then: livre source 1 -> TROCA_JOGADOR; 0 -> PROX_MACRO.
- PROX_MACRO (0x8): sinal_macro=0, registraR_macro=1, so macro<=micro. Next: TROCA_JOGADOR.
- TROCA_JOGADOR (0x9):
  - jogador toggles on exit.
  - livre=1 -> ESPERA_MACRO; livre=0 -> ESPERA_MICRO.
- FIM (0xE):
  - pronto=1; holds registers.
  - iniciar=1 -> PREPARA (jogador reset there).
- FIM_TIMEOUT (0xF):
  - timeout=1; jogador holds the offender.
  - iniciar=1 -> PREPARA.
- Unused encodings (0xA–0xD) -> INICIAL.
- Timeout counter:
  - Cleared on every cycle not in ESPERA_MACRO/ESPERA_MICRO, so each wait state starts at 0.
  - Increments each cycle in a wait state without tem_jogada.
  - Expiry: when count==TIMEOUT_CICLOS-1 with no tem_jogada, the next state is FIM_TIMEOUT. Expiry therefore occurs after exactly TIMEOUT_CICLOS wait cycles.
  - tem_jogada and expiry in the same cycle: the move wins.
- tem_jogada outside wait states is ignored; the edge detector is not re-zeroed per move.
- iniciar outside INICIAL/FIM/FIM_TIMEOUT is ignored.
- Reset mid-game returns to INICIAL immediately, regardless of state.
- Latency:
  - Move accepted to next wait state: 5 cycles with free macro (REG_MICRO, ESPERA_RAM, VERIFICA, TROCA, wait).
  - 6 cycles with forced macro (adds PROX_MACRO).

Decomposition:
- Shared package `jogo_pkg` holds:
  - State encoding localparams (4-bit values above).
  - JOGADOR_X=0, JOGADOR_O=1.
- Natural sub-module: `contador_timeout` (enable, clear, parameter TIMEOUT_CICLOS, output `fim`). Instantiated once.
- FSM next-state and output logic stay in this module.

Test Plan:
1. Reset low then high, iniciar=1 for one cycle.
   - Required: db_estado 0x0 -> 0x1 -> 0x2.
   - In 0x1: zeraEdge, zeraR_micro and zeraR_macro all 1.
   - In 0x2: sinal_macro=1, jogador=0.
2. In ESPERA_MACRO pulse tem_jogada, then in ESPERA_MICRO pulse tem_jogada with escolhe_macro=0, fim_jogo=0.
   - Required sequence: 0x3 (registraR_macro=1, sinal_macro=1), 0x4, 0x5 (registraR_micro=1), 0x6, 0x7, 0x8 (registraR_macro=1, sinal_macro=0), 0x9, 0x4.
   - jogador=1 after 0x9.
3. Same as 2 with escolhe_macro=1 at VERIFICA.
   - Required: path 0x7 -> 0x9 -> 0x2; no registraR_macro pulse; jogador toggles.
4. TIMEOUT_CICLOS=8, no tem_jogada in ESPERA_MICRO.
   - Required: after 8 cycles in 0x4, state 0xF, timeout=1, jogador unchanged.
   - Repeat with tem_jogada on the 8th cycle -> 0x5, timeout stays 0.
5. fim_jogo=1 and escolhe_macro=1 at VERIFICA.
   - Required: 0xE, pronto=1.
   - Then iniciar=1 -> 0x1, jogador=0, pronto=0.
6. Assert reset=0 asynchronously mid-cycle while in 0x5.
   - Required: state 0x0 and all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the ultimate tic-tac-toe game controller:
// state encoding, player codes and the control-strobe bundle.
package jogo_pkg;

  localparam logic [3:0] ST_INICIAL        = 4'h0;
  localparam logic [3:0] ST_PREPARA        = 4'h1;
  localparam logic [3:0] ST_ESPERA_MACRO   = 4'h2;
  localparam logic [3:0] ST_REGISTRA_MACRO = 4'h3;
  localparam logic [3:0] ST_ESPERA_MICRO   = 4'h4;
  localparam logic [3:0] ST_REGISTRA_MICRO = 4'h5;
  localparam logic [3:0] ST_ESPERA_RAM     = 4'h6;
  localparam logic [3:0] ST_VERIFICA       = 4'h7;
  localparam logic [3:0] ST_PROX_MACRO     = 4'h8;
  localparam logic [3:0] ST_TROCA_JOGADOR  = 4'h9;
  localparam logic [3:0] ST_FIM            = 4'hE;
  localparam logic [3:0] ST_FIM_TIMEOUT    = 4'hF;

  localparam logic JOGADOR_X = 1'b0;
  localparam logic JOGADOR_O = 1'b1;

  typedef struct packed {
    logic zera_edge;
    logic zera_micro;
    logic zera_macro;
    logic registra_micro;
    logic registra_macro;
    logic sinal_macro;
    logic pronto;
    logic timeout;
  } ctrl_t;

  // States in which a player move is awaited and the timeout counter runs
  function automatic logic em_espera(input logic [3:0] st);
    return (st == ST_ESPERA_MACRO) || (st == ST_ESPERA_MICRO);
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the game controller and the datapath.
interface unidade_controle_jogo_if;

  logic       iniciar;
  logic       tem_jogada;
  logic       escolhe_macro;
  logic       fim_jogo;
  logic       zeraEdge;
  logic       zeraR_micro;
  logic       zeraR_macro;
  logic       registraR_micro;
  logic       registraR_macro;
  logic       sinal_macro;
  logic       jogador;
  logic       pronto;
  logic       timeout;
  logic [3:0] db_estado;

  // Datapath / top-level side
  modport master (
    output iniciar, tem_jogada, escolhe_macro, fim_jogo,
    input  zeraEdge, zeraR_micro, zeraR_macro, registraR_micro, registraR_macro,
    input  sinal_macro, jogador, pronto, timeout, db_estado
  );

  // Controller side
  modport slave (
    input  iniciar, tem_jogada, escolhe_macro, fim_jogo,
    output zeraEdge, zeraR_micro, zeraR_macro, registraR_micro, registraR_macro,
    output sinal_macro, jogador, pronto, timeout, db_estado
  );

endinterface

// File: rtl/contador_timeout.sv
// Per-move wait counter; fim flags the last allowed cycle of a wait.
module contador_timeout #(
  parameter int unsigned TIMEOUT_CICLOS = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic fim
);

  localparam int unsigned CONT_W = $clog2(TIMEOUT_CICLOS);
  localparam logic [CONT_W-1:0] ULTIMO = CONT_W'(TIMEOUT_CICLOS - 1);

  logic [CONT_W-1:0] contagem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (clear) begin
      contagem <= '0;
    end else if (enable) begin
      contagem <= contagem + CONT_W'(1);
    end
  end

  assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore controller sequencing the ultimate tic-tac-toe datapath:
// register strobes, macro mux select, player tracking and move timeout.
module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 5000
) (
  input  logic                    clock,
  input  logic                    reset,
  unidade_controle_jogo_if.slave  bus
);

  logic [3:0] estado;
  logic [3:0] estado_prox;
  logic       jogador_q;
  logic       livre;
  logic       espera;
  logic       fim_contagem;
  ctrl_t      ctrl;

  assign espera = em_espera(estado);

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_contador (
    .clock  (clock),
    .reset  (reset),
    .enable (espera & ~bus.tem_jogada),
    .clear  (~espera),
    .fim    (fim_contagem)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= ST_INICIAL;
    end else begin
      estado <= estado_prox;
    end
  end

  // Player and free-macro flag; player cleared on entry to PREPARA so it reads X there
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogador_q <= JOGADOR_X;
      livre     <= 1'b0;
    end else begin
      if (estado_prox == ST_PREPARA) begin
        jogador_q <= JOGADOR_X;
      end else if (estado == ST_TROCA_JOGADOR) begin
        jogador_q <= ~jogador_q;
      end
      if ((estado == ST_VERIFICA) && !bus.fim_jogo) begin
        livre <= bus.escolhe_macro;
      end
    end
  end

  // Next-state logic; a move beats an expiring counter in the same cycle
  always_comb begin
    estado_prox = estado;
    case (estado)
      ST_INICIAL:        if (bus.iniciar) estado_prox = ST_PREPARA;
      ST_PREPARA:        estado_prox = ST_ESPERA_MACRO;
      ST_ESPERA_MACRO: begin
        if (bus.tem_jogada)     estado_prox = ST_REGISTRA_MACRO;
        else if (fim_contagem)  estado_prox = ST_FIM_TIMEOUT;
      end
      ST_REGISTRA_MACRO: estado_prox = ST_ESPERA_MICRO;
      ST_ESPERA_MICRO: begin
        if (bus.tem_jogada)     estado_prox = ST_REGISTRA_MICRO;
        else if (fim_contagem)  estado_prox = ST_FIM_TIMEOUT;
      end
      ST_REGISTRA_MICRO: estado_prox = ST_ESPERA_RAM;
      ST_ESPERA_RAM:     estado_prox = ST_VERIFICA;
      ST_VERIFICA: begin
        if (bus.fim_jogo)           estado_prox = ST_FIM;
        else if (bus.escolhe_macro) estado_prox = ST_TROCA_JOGADOR;
        else                        estado_prox = ST_PROX_MACRO;
      end
      ST_PROX_MACRO:     estado_prox = ST_TROCA_JOGADOR;
      ST_TROCA_JOGADOR:  estado_prox = livre ? ST_ESPERA_MACRO : ST_ESPERA_MICRO;
      ST_FIM,
      ST_FIM_TIMEOUT:    if (bus.iniciar) estado_prox = ST_PREPARA;
      default:           estado_prox = ST_INICIAL;
    endcase
  end

  // Moore output decode
  always_comb begin
    ctrl = '0;
    case (estado)
      ST_PREPARA: begin
        ctrl.zera_edge  = 1'b1;
        ctrl.zera_micro = 1'b1;
        ctrl.zera_macro = 1'b1;
      end
      ST_ESPERA_MACRO:   ctrl.sinal_macro = 1'b1;
      ST_REGISTRA_MACRO: begin
        ctrl.sinal_macro    = 1'b1;
        ctrl.registra_macro = 1'b1;
      end
      ST_REGISTRA_MICRO: ctrl.registra_micro = 1'b1;
      ST_PROX_MACRO:     ctrl.registra_macro = 1'b1;
      ST_FIM:            ctrl.pronto  = 1'b1;
      ST_FIM_TIMEOUT:    ctrl.timeout = 1'b1;
      default:           ctrl = '0;
    endcase
  end

  assign bus.zeraEdge        = ctrl.zera_edge;
  assign bus.zeraR_micro     = ctrl.zera_micro;
  assign bus.zeraR_macro     = ctrl.zera_macro;
  assign bus.registraR_micro = ctrl.registra_micro;
  assign bus.registraR_macro = ctrl.registra_macro;
  assign bus.sinal_macro     = ctrl.sinal_macro;
  assign bus.pronto          = ctrl.pronto;
  assign bus.timeout         = ctrl.timeout;
  assign bus.jogador         = jogador_q;
  assign bus.db_estado       = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench: directed vector table, timeout/reset sequences,
// then randomized play against a behavioural game model.
module tb_unidade_controle_jogo;

  localparam int unsigned TO = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  unidade_controle_jogo_if bus ();

  unidade_controle_jogo #(.TIMEOUT_CICLOS(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       ini;
    logic       tem;
    logic       esc;
    logic       fim;
    logic [3:0] est;
    logic       jog;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  vec_t tab[$];

  // Model of the game as seen from outside
  int m_st;
  int m_wait;
  int m_turns;
  bit m_livre;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobes expected in each state: {zeraEdge,zeraR_micro,zeraR_macro,regMicro,regMacro,sinal,pronto,timeout}
  function automatic logic [7:0] exp_strobes(input int st);
    case (st)
      1:       return 8'b1110_0000;
      2:       return 8'b0000_0100;
      3:       return 8'b0000_1100;
      5:       return 8'b0001_0000;
      8:       return 8'b0000_1000;
      14:      return 8'b0000_0010;
      15:      return 8'b0000_0001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] act_strobes();
    return {bus.zeraEdge, bus.zeraR_micro, bus.zeraR_macro, bus.registraR_micro,
            bus.registraR_macro, bus.sinal_macro, bus.pronto, bus.timeout};
  endfunction

  task automatic check_all(input string tag, input int st, input int jog);
    check({tag, "_estado"}, int'(bus.db_estado), st);
    check({tag, "_jogador"}, int'(bus.jogador), jog);
    check({tag, "_strobes"}, int'(act_strobes()), int'(exp_strobes(st)));
  endtask

  task automatic drive(input logic ini, input logic tem, input logic esc, input logic fim);
    bus.iniciar       = ini;
    bus.tem_jogada    = tem;
    bus.escolhe_macro = esc;
    bus.fim_jogo      = fim;
  endtask

  // Called at a falling edge: apply inputs across one rising edge, check at the next falling edge
  task automatic run_vec(input string tag, input vec_t v);
    drive(v.ini, v.tem, v.esc, v.fim);
    @(posedge clock);
    @(negedge clock);
    check_all(tag, int'(v.est), int'(v.jog));
  endtask

  task automatic add(input logic ini, input logic tem, input logic esc, input logic fim,
                     input logic [3:0] est, input logic jog);
    vec_t v;
    v.ini = ini; v.tem = tem; v.esc = esc; v.fim = fim; v.est = est; v.jog = jog;
    tab.push_back(v);
  endtask

  task automatic model_reset();
    m_st = 0; m_wait = 0; m_turns = 0; m_livre = 1'b0;
  endtask

  task automatic model_step(input bit ini, input bit tem, input bit esc, input bit fim);
    int nxt;
    nxt = m_st;
    case (m_st)
      0:      if (ini) nxt = 1;
      1:      nxt = 2;
      2, 4: begin
        if (tem)                 nxt = m_st + 1;
        else if (m_wait + 1 == TO) nxt = 15;
      end
      3:      nxt = 4;
      5:      nxt = 6;
      6:      nxt = 7;
      7: begin
        if (fim) nxt = 14;
        else begin
          m_livre = esc;
          nxt = esc ? 9 : 8;
        end
      end
      8:      nxt = 9;
      9: begin
        m_turns++;
        nxt = m_livre ? 2 : 4;
      end
      14, 15: if (ini) nxt = 1;
      default: nxt = 0;
    endcase
    m_wait = (nxt == m_st && (nxt == 2 || nxt == 4)) ? m_wait + 1 : 0;
    if (nxt == 1) m_turns = 0;
    m_st = nxt;
  endtask

  initial begin
    bit ini, tem, esc, fim;
    drive(0, 0, 0, 0);
    #12;
    check_all("reset", 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_all("idle", 0, 0);

    // Start, forced-macro move, free-macro move, then game over and restart
    add(1,0,0,0, 4'h1, 0);
    add(0,0,0,0, 4'h2, 0);
    add(0,1,0,0, 4'h3, 0);
    add(0,0,0,0, 4'h4, 0);
    add(0,1,0,0, 4'h5, 0);
    add(0,0,0,0, 4'h6, 0);
    add(0,0,0,0, 4'h7, 0);
    add(0,0,0,0, 4'h8, 0);
    add(0,0,0,0, 4'h9, 0);
    add(0,0,0,0, 4'h4, 1);
    add(0,1,0,0, 4'h5, 1);
    add(0,0,0,0, 4'h6, 1);
    add(0,0,0,0, 4'h7, 1);
    add(0,0,1,0, 4'h9, 1);
    add(0,0,0,0, 4'h2, 0);
    add(0,1,0,0, 4'h3, 0);
    add(0,0,0,0, 4'h4, 0);
    add(0,1,0,0, 4'h5, 0);
    add(0,0,0,0, 4'h6, 0);
    add(0,0,0,0, 4'h7, 0);
    add(0,0,1,1, 4'hE, 0);
    add(0,1,0,0, 4'hE, 0);
    add(1,0,0,0, 4'h1, 0);
    add(0,0,0,0, 4'h2, 0);
    for (int i = 0; i < tab.size(); i++) run_vec($sformatf("vec%0d", i), tab[i]);

    // Timeout in ESPERA_MICRO after exactly TO idle cycles, offender kept
    run_vec("to_m", '{0,1,0,0, 4'h3, 0});
    run_vec("to_w", '{0,0,0,0, 4'h4, 0});
    for (int i = 1; i < TO; i++) run_vec($sformatf("to_idle%0d", i), '{0,0,0,0, 4'h4, 0});
    run_vec("to_exp", '{0,0,0,0, 4'hF, 0});
    run_vec("to_hold", '{0,1,0,0, 4'hF, 0});
    run_vec("to_rst", '{1,0,0,0, 4'h1, 0});
    run_vec("mv_w", '{0,0,0,0, 4'h2, 0});
    run_vec("mv_m", '{0,1,0,0, 4'h3, 0});
    run_vec("mv_w2", '{0,0,0,0, 4'h4, 0});
    for (int i = 1; i < TO; i++) run_vec($sformatf("mv_idle%0d", i), '{0,0,0,0, 4'h4, 0});
    run_vec("mv_last", '{0,1,0,0, 4'h5, 0});

    // Asynchronous reset while in REGISTRA_MICRO
    drive(0, 0, 0, 0);
    #2 reset = 1'b0;
    #1 check_all("async_rst", 0, 0);
    @(negedge clock);
    check_all("rst_hold", 0, 0);
    reset = 1'b1;
    model_reset();

    // Randomized play against the model
    for (int c = 0; c < 3000; c++) begin
      check_all("rand", m_st, m_turns % 2);
      ini = ($urandom_range(0, 7) == 0);
      tem = ($urandom_range(0, 3) == 0);
      esc = $urandom_range(0, 1) != 0;
      fim = ($urandom_range(0, 3) == 0);
      drive(ini, tem, esc, fim);
      @(posedge clock);
      model_step(ini, tem, esc, fim);
      @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
